// File: rtl/addshare64.sv
// addshare64: two-client valid/ready arbiter and 2-stage pipeline around a shared 64-bit Ladner-Fischer adder.
// Optional feature: define ADDSHARE_SUB_EN to add per-client subtract ports (reqN_sub_i).
module addshare64 #(
  parameter int RR = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [63:0] req0_a_i,
  input  logic [63:0] req0_b_i,
  input  logic        req0_cin_i,
`ifdef ADDSHARE_SUB_EN
  input  logic        req0_sub_i,
`endif
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [63:0] req1_a_i,
  input  logic [63:0] req1_b_i,
  input  logic        req1_cin_i,
`ifdef ADDSHARE_SUB_EN
  input  logic        req1_sub_i,
`endif
  output logic        rsp0_valid_o,
  input  logic        rsp0_ready_i,
  output logic [63:0] rsp0_sum_o,
  output logic        rsp0_cout_o,
  output logic        rsp1_valid_o,
  input  logic        rsp1_ready_i,
  output logic [63:0] rsp1_sum_o,
  output logic        rsp1_cout_o,
  output logic        busy_o
);

  // Sklansky/Ladner-Fischer prefix: cin is folded into bit 0's generate, so g[i] ends up as carry out of bit i.
  function automatic logic [64:0] lfAdd(input logic [63:0] a, input logic [63:0] b, input logic cin);
    logic [63:0] g;
    logic [63:0] p;
    logic [63:0] x;
    logic [5:0]  hi;
    logic [5:0]  lo;
    x    = a ^ b;
    g    = a & b;
    p    = x;
    g[0] = g[0] | (x[0] & cin);
    for (int l = 0; l < 6; l++) begin
      for (int i = 0; i < 64; i++) begin
        if (((i >> l) & 1) == 1) begin
          hi    = 6'(i);
          lo    = 6'(((i >> l) << l) - 1);
          g[hi] = g[hi] | (p[hi] & g[lo]);
          p[hi] = p[hi] & p[lo];
        end
      end
    end
    return {g[63], x ^ {g[62:0], cin}};
  endfunction

  logic        v1_q, v1_d, v2_q, v2_d;
  logic        id1_q, id1_d, id2_q, id2_d;
  logic        ptr_q, ptr_d;
  logic        cin1_q, cin1_d, cout2_q, cout2_d;
  logic [63:0] a1_q, a1_d, b1_q, b1_d, sum2_q, sum2_d;

  logic        s2Drain, s2Free, s1Adv, s1Free;
  logic        grant0, grant1, acc0, acc1;
  logic [63:0] selB;
  logic        selCin;
  logic [64:0] addRes;

  assign s2Drain = v2_q & (id2_q ? rsp1_ready_i : rsp0_ready_i);
  assign s2Free  = ~v2_q | s2Drain;
  assign s1Adv   = v1_q & s2Free;
  assign s1Free  = ~v1_q | s1Adv;

  // Grants look only at the other client's valid, so readyN never depends on reqN_valid.
  generate
    if (RR != 0) begin : g_rr
      assign grant0 = ~req1_valid_i | ptr_q;
      assign grant1 = ~req0_valid_i | ~ptr_q;
    end else begin : g_fixed
      assign grant0 = 1'b1;
      assign grant1 = ~req0_valid_i;
    end
  endgenerate

  assign req0_ready_o = s1Free & grant0;
  assign req1_ready_o = s1Free & grant1;
  assign acc0         = req0_valid_i & req0_ready_o;
  assign acc1         = req1_valid_i & req1_ready_o;

  always_comb begin
    selB   = acc1 ? req1_b_i : req0_b_i;
    selCin = acc1 ? req1_cin_i : req0_cin_i;
`ifdef ADDSHARE_SUB_EN
    if (acc1 ? req1_sub_i : req0_sub_i) begin
      selB   = ~selB;
      selCin = 1'b1;
    end
`endif
  end

  assign addRes = lfAdd(a1_q, b1_q, cin1_q);

  always_comb begin
    v1_d    = v1_q;
    a1_d    = a1_q;
    b1_d    = b1_q;
    cin1_d  = cin1_q;
    id1_d   = id1_q;
    ptr_d   = ptr_q;
    v2_d    = v2_q;
    sum2_d  = sum2_q;
    cout2_d = cout2_q;
    id2_d   = id2_q;
    if (s1Free) begin
      v1_d = acc0 | acc1;
    end
    if (acc0 | acc1) begin
      a1_d   = acc1 ? req1_a_i : req0_a_i;
      b1_d   = selB;
      cin1_d = selCin;
      id1_d  = acc1;
      ptr_d  = acc1;
    end
    if (s1Adv) begin
      v2_d    = 1'b1;
      sum2_d  = addRes[63:0];
      cout2_d = addRes[64];
      id2_d   = id1_q;
    end else if (s2Drain) begin
      v2_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      v1_q    <= 1'b0;
      a1_q    <= '0;
      b1_q    <= '0;
      cin1_q  <= 1'b0;
      id1_q   <= 1'b0;
      ptr_q   <= 1'b1;
      v2_q    <= 1'b0;
      sum2_q  <= '0;
      cout2_q <= 1'b0;
      id2_q   <= 1'b0;
    end else begin
      v1_q    <= v1_d;
      a1_q    <= a1_d;
      b1_q    <= b1_d;
      cin1_q  <= cin1_d;
      id1_q   <= id1_d;
      ptr_q   <= ptr_d;
      v2_q    <= v2_d;
      sum2_q  <= sum2_d;
      cout2_q <= cout2_d;
      id2_q   <= id2_d;
    end
  end

  assign rsp0_valid_o = v2_q & ~id2_q;
  assign rsp1_valid_o = v2_q & id2_q;
  assign rsp0_sum_o   = sum2_q;
  assign rsp1_sum_o   = sum2_q;
  assign rsp0_cout_o  = cout2_q;
  assign rsp1_cout_o  = cout2_q;
  assign busy_o       = v1_q | v2_q;

endmodule
